// File: rtl/simon_pkg.sv
// Shared Simon definitions: colour codes, player state encoding, bus widths.
// Used by the sequence memory, the game FSM and the sequence player.
package simon_pkg;

  localparam int LEVEL_W = 3;
  localparam int COLOR_W = 2;
  localparam int LED_W   = 1 << COLOR_W;

  typedef enum logic [COLOR_W-1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } player_state_t;

  function automatic logic [LED_W-1:0] color_onehot(input logic [COLOR_W-1:0] c);
    logic [LED_W-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter: counts while enabled, flags terminal count against a runtime limit.
// tc is combinational from the count; the count wraps to 0 on the enabled tc cycle.
module phase_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sequence_player.sv
// Replays stored Simon colours 0..level: fetch, light LED for ON_CYCLES, blank OFF_CYCLES.
// First LED one cycle after start; done pulses N*(1+ON+OFF) cycles after start; start ignored while busy.
import simon_pkg::*;

module sequence_player #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] level,
  output logic [2:0] mem_addr,
  input  logic [1:0] mem_data,
  output logic [1:0] color,
  output logic [3:0] led,
  output logic       led_on,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_CYCLES - 1);

  player_state_t        state_q, state_d;
  logic [LEVEL_W-1:0]   last_idx_q, last_idx_d;
  logic [LEVEL_W-1:0]   mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 led_on_q, led_on_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tmr_clear;
  logic                 tmr_en;
  logic [CNT_W-1:0]     tmr_limit;
  logic                 tmr_tc;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (reset),
    .clear (tmr_clear),
    .en    (tmr_en),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_SHOW;
      ST_SHOW:  if (tmr_tc) state_d = ST_GAP;
      ST_GAP:   if (tmr_tc) state_d = (mem_addr_q == last_idx_q) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a start in the same IDLE cycle.
    if (abort) state_d = ST_IDLE;
  end

  always_comb begin
    last_idx_d = last_idx_q;
    mem_addr_d = mem_addr_q;
    color_d    = color_q;

    if (state_q == ST_IDLE && start) begin
      last_idx_d = level;
      mem_addr_d = '0;
    end
    if (state_q == ST_FETCH) color_d = mem_data;
    if (state_q == ST_GAP && tmr_tc && mem_addr_q != last_idx_q) begin
      mem_addr_d = mem_addr_q + LEVEL_W'(1);
    end
    if (state_d == ST_IDLE) mem_addr_d = '0;

    // Registered status flags follow the state being entered so they align with it.
    led_on_d = (state_d == ST_SHOW);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);

    tmr_clear = abort || (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_DONE);
    tmr_en    = (state_q == ST_SHOW) || (state_q == ST_GAP);
    tmr_limit = (state_q == ST_GAP) ? OFF_LIM : ON_LIM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx_q <= '0;
      mem_addr_q <= '0;
      color_q    <= '0;
      led_on_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      last_idx_q <= last_idx_d;
      mem_addr_q <= mem_addr_d;
      color_q    <= color_d;
      led_on_q   <= led_on_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign color    = color_q;
  assign led_on   = led_on_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign led      = led_on_q ? color_onehot(color_q) : '0;

endmodule
